// File: rtl/maze_store_if.sv
// Bundle of load stream, solver access port and dump stream
// shared between maze_store and its neighbours.
interface maze_store_if #(
  parameter int maze_width = 6
);
  logic                  start;
  logic                  load_valid;
  logic                  load_bit;
  logic                  load_ready;
  logic                  solve_start;
  logic [maze_width-1:0] row;
  logic [maze_width-1:0] col;
  logic                  maze_oe;
  logic                  maze_we;
  logic                  maze_in;
  logic                  done;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;
  logic [maze_width-1:0] out_row;
  logic [maze_width-1:0] out_col;
  logic                  dump_done;

  modport master (
    output start, load_valid, load_bit,
    output row, col, maze_oe, maze_we, done,
    output out_ready,
    input  load_ready, solve_start, maze_in,
    input  out_valid, out_bit, out_row, out_col,
    input  dump_done
  );

  modport slave (
    input  start, load_valid, load_bit,
    input  row, col, maze_oe, maze_we, done,
    input  out_ready,
    output load_ready, solve_start, maze_in,
    output out_valid, out_bit, out_row, out_col,
    output dump_done
  );
endinterface

// File: rtl/maze_store.sv
// Wall/path cell store: bit-serial load, solver read/mark port,
// and row-major dump of the marked path.
module maze_store #(
  parameter int maze_width = 6
) (
  input logic         clk,
  input logic         rst,
  maze_store_if.slave bus
);
  localparam int n = 2 * maze_width;
  localparam int cells = 1 << n;
  localparam logic [n-1:0] one = 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SOLVE, DUMP, END
  } state_t;

  state_t state, state_d;

  logic wall [cells];
  logic path [cells];

  logic [n-1:0] cnt, dcnt, dnext, sel;
  logic ld_rdy, load_fire, dump_fire;
  logic last_load, last_dump, take_start;
  logic solve_q, rd_q, ov_q, ob_q, dd_q;
  logic [maze_width-1:0] orow_q, ocol_q;

  assign sel   = {bus.row, bus.col};
  assign dnext = dcnt + one;

  always_comb begin
    state_d    = state;
    ld_rdy     = 1'b0;
    load_fire  = 1'b0;
    dump_fire  = 1'b0;
    last_load  = 1'b0;
    last_dump  = 1'b0;
    take_start = 1'b0;
    unique case (state)
      IDLE: begin
        take_start = bus.start;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        ld_rdy    = 1'b1;
        load_fire = bus.load_valid;
        last_load = load_fire && (&cnt);
        if (last_load) state_d = SOLVE;
      end
      SOLVE: begin
        if (bus.done) state_d = DUMP;
      end
      DUMP: begin
        dump_fire = ov_q && bus.out_ready;
        last_dump = dump_fire && (&dcnt);
        if (last_dump) state_d = END;
      end
      END: begin
        take_start = bus.start;
        if (bus.start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      solve_q <= 1'b0;
      rd_q    <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      dd_q    <= 1'b0;
    end else begin
      state   <= state_d;
      solve_q <= last_load;
      if (take_start) begin
        cnt  <= '0;
        dd_q <= 1'b0;
      end else if (load_fire) begin
        cnt <= cnt + one;
      end
      if (state == SOLVE && bus.maze_oe)
        rd_q <= wall[sel];
      if (state == SOLVE && bus.done)
        dcnt <= '0;
      // First DUMP cycle primes the output register from dcnt.
      if (state == DUMP) begin
        if (!ov_q) begin
          ov_q             <= 1'b1;
          ob_q             <= path[dcnt];
          {orow_q, ocol_q} <= dcnt;
        end else if (dump_fire) begin
          if (last_dump) begin
            ov_q <= 1'b0;
            dd_q <= 1'b1;
          end else begin
            dcnt             <= dnext;
            ob_q             <= path[dnext];
            {orow_q, ocol_q} <= dnext;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      wall[cnt] <= bus.load_bit;
      path[cnt] <= 1'b0;
    end
    if (state == SOLVE && bus.maze_we)
      path[sel] <= 1'b1;
  end

  assign bus.load_ready  = ld_rdy;
  assign bus.solve_start = solve_q;
  assign bus.maze_in     = rd_q;
  assign bus.out_valid   = ov_q;
  assign bus.out_bit     = ob_q;
  assign bus.out_row     = orow_q;
  assign bus.out_col     = ocol_q;
  assign bus.dump_done   = dd_q;
endmodule

// File: tb/tb_maze_store.sv
// Scoreboard bench for maze_store with a 4x4 maze.
module tb_maze_store;
  localparam int w = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_store_if #(.maze_width(w)) bus();

  maze_store #(.maze_width(w)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int ss_cnt = 0;

  logic [4:0] dq [$];
  logic       rq [$];
  logic       rd_seen = 1'b0;
  logic       hold_pend = 1'b0;
  logic [4:0] held;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    rd_seen <= bus.maze_oe && !rst;
    if (bus.solve_start) ss_cnt <= ss_cnt + 1;
  end

  // Monitor: compares dump beats and read data against the queues.
  always @(negedge clk) begin
    logic [4:0] cur;
    logic [4:0] exp;
    logic       rexp;
    cur = {bus.out_bit, bus.out_row, bus.out_col};
    if (rst) begin
      hold_pend = 1'b0;
    end else if (bus.out_valid) begin
      if (hold_pend) chk("hold", 32'(cur), 32'(held));
      if (bus.out_ready) begin
        hold_pend = 1'b0;
        if (dq.size() == 0) begin
          chk("dump_extra", 32'(cur), 32'h1f_ffff);
        end else begin
          exp = dq.pop_front();
          chk("dump_beat", 32'(cur), 32'(exp));
        end
        beats++;
      end else begin
        hold_pend = 1'b1;
        held      = cur;
      end
    end else begin
      hold_pend = 1'b0;
    end
    if (rd_seen) begin
      if (rq.size() == 0) begin
        chk("read_extra", 32'(bus.maze_in), 32'h2);
      end else begin
        rexp = rq.pop_front();
        chk("maze_in", 32'(bus.maze_in), 32'(rexp));
      end
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_ready", 32'(bus.load_ready), 32'h1);
    chk("dump_done_clr", 32'(bus.dump_done), 32'h0);
  endtask

  // sel: 0 = bit0 of index, 1 = bit1 of index, 2 = all free
  task automatic do_load(int sel, bit stall);
    int ss0;
    logic [3:0] idx;
    ss0 = ss_cnt;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (stall) begin
        bus.load_valid = 1'b0;
        tick();
      end
      if (i == 15)
        chk("no_early_solve", 32'(bus.solve_start), 32'h0);
      bus.load_valid = 1'b1;
      bus.load_bit = (sel == 0) ? idx[0] :
                     (sel == 1) ? idx[1] : 1'b0;
      tick();
    end
    bus.load_valid = 1'b0;
    chk("solve_start_hi", 32'(bus.solve_start), 32'h1);
    chk("load_ready_off", 32'(bus.load_ready), 32'h0);
    tick();
    chk("solve_start_lo", 32'(bus.solve_start), 32'h0);
    chk("solve_pulses", 32'(ss_cnt - ss0), 32'h1);
  endtask

  task automatic access(int r, int c, bit oe, bit we, bit exp);
    bus.row     = 2'(r);
    bus.col     = 2'(c);
    bus.maze_oe = oe;
    bus.maze_we = we;
    if (oe) rq.push_back(exp);
    tick();
    bus.maze_oe = 1'b0;
    bus.maze_we = 1'b0;
  endtask

  task automatic push_dump(logic [15:0] marks);
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      dq.push_back({marks[i], idx});
    end
  endtask

  task automatic begin_dump();
    bus.out_ready = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("valid_delay", 32'(bus.out_valid), 32'h0);
  endtask

  task automatic wait_beats(int target);
    int k = 0;
    while (beats < target && k < 200) begin
      tick();
      k++;
    end
    if (beats < target)
      chk("beat_timeout", 32'(beats), 32'(target));
  endtask

  task automatic finish_dump(int base);
    int k = 0;
    while (!bus.dump_done && k < 200) begin
      tick();
      k++;
    end
    chk("dump_done", 32'(bus.dump_done), 32'h1);
    chk("valid_drop", 32'(bus.out_valid), 32'h0);
    chk("beat_count", 32'(beats - base), 32'd16);
    chk("queue_empty", 32'(dq.size()), 32'h0);
  endtask

  initial begin
    int base;
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_bit   = 1'b0;
    bus.row        = '0;
    bus.col        = '0;
    bus.maze_oe    = 1'b0;
    bus.maze_we    = 1'b0;
    bus.done       = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_load_ready", 32'(bus.load_ready), 32'h0);
    chk("rst_solve", 32'(bus.solve_start), 32'h0);
    chk("rst_maze_in", 32'(bus.maze_in), 32'h0);
    chk("rst_out", {bus.out_valid, bus.out_bit,
        bus.out_row, bus.out_col, bus.dump_done}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.load_ready), 32'h0);

    // Run 1: continuous load, reads, marks, dump with backpressure.
    do_start();
    do_load(0, 1'b0);
    access(1, 2, 1'b1, 1'b0, 1'b0);
    access(3, 3, 1'b1, 1'b0, 1'b1);
    access(0, 0, 1'b0, 1'b1, 1'b0);
    access(0, 1, 1'b0, 1'b1, 1'b0);
    access(1, 1, 1'b0, 1'b1, 1'b0);
    tick();
    base = beats;
    push_dump(16'h0023);
    begin_dump();
    wait_beats(base + 6);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    finish_dump(base);
    bus.out_ready = 1'b0;
    tick();
    chk("done_sticky", 32'(bus.dump_done), 32'h1);
    access(2, 2, 1'b0, 1'b1, 1'b0);

    // Run 2: stalled load, simultaneous read/mark, reset mid-dump.
    do_start();
    do_load(1, 1'b1);
    access(0, 2, 1'b1, 1'b0, 1'b1);
    access(0, 1, 1'b1, 1'b0, 1'b0);
    access(2, 2, 1'b1, 1'b1, 1'b1);
    access(3, 0, 1'b0, 1'b1, 1'b0);
    tick();
    base = beats;
    push_dump(16'h1400);
    begin_dump();
    wait_beats(base + 12);
    rst = 1'b1;
    #1;
    chk("async_rst_out", {bus.out_valid, bus.out_bit,
        bus.out_row, bus.out_col, bus.dump_done}, 32'h0);
    chk("async_rst_ready", 32'(bus.load_ready), 32'h0);
    dq.delete();
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Run 3: fresh all-free maze, no marks expected anywhere.
    do_start();
    do_load(2, 1'b0);
    access(2, 2, 1'b1, 1'b0, 1'b0);
    tick();
    base = beats;
    push_dump(16'h0000);
    begin_dump();
    finish_dump(base);
    chk("reads_left", 32'(rq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maze_store.md
# maze_store

Cell storage and sequencing stage that sits directly upstream of the maze solver and also receives its results. It loads a square wall bitmap from a bit-serial valid/ready stream and answers the solver's synchronous read (`maze_oe`) and path-mark (`maze_we`) requests. After the solver raises `done`, it streams the marked path back out in row-major order.

## Interface
Parameters:
- `maze_width`, default 6: coordinate width; the maze is 2^maze_width × 2^maze_width cells (64×64 by default).

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `start`  in  1  One-cycle request to begin a load; honoured only in IDLE.
- `load_valid`  in  1  Load beat valid.
- `load_bit`  in  1  Wall bit for the current cell: 1 = wall, 0 = free.
- `load_ready`  out  1  Store accepts a load beat this cycle.
- `solve_start`  out  1  One-cycle pulse when the load completes.
- `row`, `col`  in  maze_width  Solver cell select.
- `maze_oe`  in  1  Solver read enable, synchronous.
- `maze_we`  in  1  Solver path-mark enable, synchronous.
- `maze_in`  out  1  Registered wall bit of the cell read.
- `done`  in  1  Solver finished; level input.
- `out_valid`  out  1  Dump beat valid.
- `out_ready`  in  1  Downstream accepts a dump beat.
- `out_bit`  out  1  Path bit of the current dump cell.
- `out_row`, `out_col`  out  maze_width  Coordinates of the current dump cell.
- `dump_done`  out  1  Sticky flag: the dump is complete.

## Operation
- Storage has two planes of 2^(2·maze_width) bits each: `wall` and `path`. Index = {row, col}. Neither plane is reset.
- The FSM has five states: IDLE, LOAD, SOLVE, DUMP, END.
- **IDLE**
  - `load_ready` = 0.
  - `start` → LOAD; the cell counter is cleared to 0.
- **LOAD**
  - `load_ready` = 1.
  - On each `load_valid & load_ready` beat: `wall[cnt]` ← `load_bit`, `path[cnt]` ← 0, then `cnt` increments.
  - Load order is row-major: `cnt[2W-1:W]` = row, `cnt[W-1:0]` = col.
  - The beat at `cnt` = all-ones is the last one. It moves the FSM to SOLVE and pulses `solve_start` in the next cycle.
  - Gaps in `load_valid` stall the load; the count is held.
- **SOLVE**
  - `load_ready` = 0.
  - `maze_oe` samples `{row, col}` at the edge; `maze_in` ← `wall[{row, col}]`.
  - `maze_we` sets `path[{row, col}]` ← 1.
  - `maze_oe` and `maze_we` may be asserted together on the same cell: the read returns the wall bit and the mark is applied. The planes are independent, so there is no hazard.
  - `done` = 1 → DUMP; the dump counter is cleared to 0.
  - Solver requests are ignored in every state other than SOLVE.
- **DUMP**
  - Presents `path[dcnt]` with `out_row`/`out_col` = `dcnt` fields.
  - Advances on `out_valid & out_ready`.
  - After the beat at all-ones is accepted: `out_valid` drops, the FSM moves to END, and `dump_done` is set.
  - While `out_valid` is high, `out_bit`, `out_row` and `out_col` hold stable until the beat is accepted.
- **END**
  - `dump_done` = 1 and stays set.
  - `start` → LOAD: starts a new maze and clears `dump_done`.
- `start` is ignored outside IDLE and END.

## Timing
- Reset values:
  - State = IDLE.
  - `load_ready`, `solve_start`, `maze_in`, `out_valid`, `out_bit`, `out_row`, `out_col`, `dump_done` = 0.
  - Counters = 0.
- A reset mid-operation aborts immediately to IDLE; memory contents become don't-care.
- `start` to `load_ready` = 1: 1 cycle.
- Last load beat to `solve_start`: 1 cycle; `solve_start` is high for exactly 1 cycle.
- `maze_oe` at edge N → `maze_in` valid during cycle N+1. `maze_in` holds until the next `maze_oe`.
- `maze_we` at edge N → a read of the same cell at N+1 or later sees the mark (dump only).
- Entering DUMP → `out_valid` high 1 cycle later.
- Dump throughput is one beat per cycle while `out_ready` is held high.
- Total dump = 2^(2W) beats; no wrap past the last cell.
- Counter wrap: `cnt` and `dcnt` are 2W bits wide. They never wrap inside a phase, because the phase ends at all-ones.

## Test plan
- **Load and solve handshake** (`maze_width` = 2, 16 cells)
  - Stimulus: `start`, then 16 load beats with `load_bit` = cell index[0]. Then `maze_oe` at (1,2), i.e. index 6.
  - Required: `solve_start` pulses exactly once, 1 cycle after beat 16. `maze_in` = 0 one cycle later; a read at (3,3) returns 1.
- **Stalled load**
  - Stimulus: `load_valid` toggled every other cycle.
  - Required: exactly 16 cells stored; `solve_start` follows the 16th accepted beat only.
- **Path mark and dump**
  - Stimulus: mark (0,0), (0,1), (1,1) via `maze_we`, then `done` = 1, with `out_ready` held high.
  - Required: 16 beats; `out_bit` = 1 only at indices 0, 1 and 5; `dump_done` = 1 after the 16th beat.
- **Dump backpressure**
  - Stimulus: `out_ready` low for 3 cycles mid-dump.
  - Required: `out_bit`, `out_row` and `out_col` hold stable; no beat is lost or duplicated.
- **Simultaneous read and mark**
  - Stimulus: `maze_oe` = `maze_we` = 1 on wall cell (2,2).
  - Required: `maze_in` = 1; the dump shows `path` = 1 at index 10.
- **Reset mid-operation**
  - Stimulus: `rst` asserted in the middle of DUMP, then `start` and a second load.
  - Required: all outputs go to 0 asynchronously. The second run's dump shows no stale marks from the first run.
